// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read-port bundle between the FIFO and the UART drain stage
// master is the reader (drives fifo_rd); slave is the FIFO side.
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO drain stage serialising bytes as UART frames
// Fetches one word per frame through the FIFO's registered read port.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    fifo_uart_tx_if.master       fifo,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, FETCH, START, DATA, PARITY, STOP
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               rd_q, rd_d;
    logic               done_q, done_d;
    logic               baud_tc;

    assign baud_tc      = (baud_q == BAUD_LAST);
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign fifo.fifo_rd = rd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        rd_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (enable && !fifo.fifo_empty) begin
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = REQ;
                end
            end
            // FIFO registers the read on this edge; data is valid in FETCH.
            REQ: state_d = FETCH;
            FETCH: begin
                shift_d = fifo.fifo_data;
                par_d   = (PARITY_ODD != 0) ? ~^fifo.fifo_data : ^fifo.fifo_data;
                tx_d    = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                baud_d = baud_tc ? '0 : baud_q + 1'b1;
                if (baud_tc) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_tc ? '0 : baud_q + 1'b1;
                if (baud_tc) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                baud_d = baud_tc ? '0 : baud_q + 1'b1;
                if (baud_tc) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                baud_d = baud_tc ? '0 : baud_q + 1'b1;
                if (baud_tc) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx
// dut0: 8N1 behind a FIFO model; dut1: odd parity, 1 stop; dut2: even parity, 2 stops.
module tb_fifo_uart_tx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] en_v = 3'b000;
    wire  [2:0] tx_v, busy_v, done_v, rd_v;

    logic       empty0 = 1'b1;
    logic       empty0_d1 = 1'b1;
    logic [7:0] fdata0 = 8'h00;
    logic       empty1 = 1'b1;
    logic [7:0] fdata1 = 8'h00;
    logic       empty2 = 1'b1;
    logic [7:0] fdata2 = 8'h00;

    logic [7:0] mem [16];
    int wptr = 0;
    int rptr = 0;
    int rd_cnt [3] = '{0, 0, 0};
    int tests = 0;
    int fails = 0;

    fifo_uart_tx_if #(.WIDTH(8)) bus0 ();
    fifo_uart_tx_if #(.WIDTH(8)) bus1 ();
    fifo_uart_tx_if #(.WIDTH(8)) bus2 ();

    assign bus0.fifo_empty = empty0;
    assign bus0.fifo_data  = fdata0;
    assign bus1.fifo_empty = empty1;
    assign bus1.fifo_data  = fdata1;
    assign bus2.fifo_empty = empty2;
    assign bus2.fifo_data  = fdata2;
    assign rd_v = {bus2.fifo_rd, bus1.fifo_rd, bus0.fifo_rd};

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .enable(en_v[0]), .fifo(bus0.master),
        .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .enable(en_v[1]), .fifo(bus1.master),
        .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .enable(en_v[2]), .fifo(bus2.master),
        .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

    always #5 clk = ~clk;

    // FIFO model: registered read data, empty flag two cycles behind the count.
    always @(posedge clk) begin
        if (rd_v[0] && (rptr != wptr)) begin
            fdata0 <= mem[rptr % 16];
            rptr   <= rptr + 1;
        end
        empty0_d1 <= (wptr == rptr);
        empty0    <= empty0_d1;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) rd_cnt[i] <= rd_cnt[i] + int'(rd_v[i]);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wptr % 16] = b;
        wptr = wptr + 1;
    endtask

    task automatic wait_fall(input int s, input int limit, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_v[s] !== 1'b0 && n < limit);
        check(tag, 64'(tx_v[s]), 64'd0);
    endtask

    // Entered on the negedge just after tx fell; seq[0] is the start bit.
    task automatic frame(input int s, input logic [15:0] seq, input int nbits, input string tag);
        logic [63:0] wave, exp;
        logic busy_all, any_done;
        wave = '0;
        exp = '0;
        busy_all = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 4 * nbits; i++) begin
            if (i > 0) @(negedge clk);
            wave[i]  = tx_v[s];
            exp[i]   = seq[i / 4];
            busy_all = busy_all & busy_v[s];
            any_done = any_done | done_v[s];
        end
        check({tag, "_wave"}, wave, exp);
        check({tag, "_busy"}, 64'(busy_all), 64'd1);
        check({tag, "_early_done"}, 64'(any_done), 64'd0);
        @(negedge clk);
        check({tag, "_done"}, 64'(done_v[s]), 64'd1);
        check({tag, "_busy_end"}, 64'(busy_v[s]), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done_v[s]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, base;
        logic bad_rd, bad_tx, bad_busy;

        repeat (3) @(negedge clk);
        check("rst_tx", 64'(tx_v[0]), 64'd1);
        check("rst_busy", 64'(busy_v[0]), 64'd0);
        check("rst_rd", 64'(rd_v[0]), 64'd0);
        check("rst_done", 64'(done_v[0]), 64'd0);
        reset = 1'b0;

        // Empty FIFO with enable held: nothing may happen.
        en_v[0] = 1'b1;
        bad_rd = 1'b0; bad_tx = 1'b0; bad_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bad_rd   = bad_rd | rd_v[0];
            bad_tx   = bad_tx | ~tx_v[0];
            bad_busy = bad_busy | busy_v[0];
        end
        check("empty_rd", 64'(bad_rd), 64'd0);
        check("empty_tx", 64'(bad_tx), 64'd0);
        check("empty_busy", 64'(bad_busy), 64'd0);

        // Single 0xA5 frame with fetch timing.
        base = rd_cnt[0];
        push(8'hA5);
        n = 0;
        while (rd_v[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a5_rd_rise", 64'(rd_v[0]), 64'd1);
        @(negedge clk);
        check("a5_rd_pulse", 64'(rd_v[0]), 64'd0);
        check("a5_tx_hold", 64'(tx_v[0]), 64'd1);
        @(negedge clk);
        check("a5_fall_latency", 64'(tx_v[0]), 64'd0);
        frame(0, {5'b0, 1'b1, 8'hA5, 1'b0}, 10, "a5");
        check("a5_rd_count", 64'(rd_cnt[0] - base), 64'd1);

        // Three back-to-back bytes; gap counted from the frame_done cycle.
        base = rd_cnt[0];
        push(8'h01); push(8'h02); push(8'h03);
        wait_fall(0, 20, "b1_start", n);
        frame(0, {5'b0, 1'b1, 8'h01, 1'b0}, 10, "b1");
        wait_fall(0, 20, "b2_start", n);
        check("b2_gap", 64'(n + 1), 64'd3);
        frame(0, {5'b0, 1'b1, 8'h02, 1'b0}, 10, "b2");
        wait_fall(0, 20, "b3_start", n);
        check("b3_gap", 64'(n + 1), 64'd3);
        frame(0, {5'b0, 1'b1, 8'h03, 1'b0}, 10, "b3");
        repeat (6) @(negedge clk);
        check("b_rd_count", 64'(rd_cnt[0] - base), 64'd3);
        check("b_fifo_empty", 64'(empty0), 64'd1);

        // Odd parity of 0x01 is 0; frame is 44 cycles.
        fdata1 = 8'h01; empty1 = 1'b0; en_v[1] = 1'b1;
        wait_fall(1, 20, "p1_start", n);
        en_v[1] = 1'b0;
        frame(1, {4'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, "par_odd");
        check("p1_rd_count", 64'(rd_cnt[1]), 64'd1);

        // Even parity of 0x07 is 1; two stop bits.
        fdata2 = 8'h07; empty2 = 1'b0; en_v[2] = 1'b1;
        wait_fall(2, 20, "p2_start", n);
        en_v[2] = 1'b0;
        frame(2, {3'b0, 2'b11, 1'b1, 8'h07, 1'b0}, 12, "par_even");

        // 0xFF with two stop bits; enable dropped during data bit 3.
        fdata2 = 8'hFF; en_v[2] = 1'b1;
        wait_fall(2, 20, "ff_start", n);
        fork
            frame(2, {3'b0, 2'b11, 1'b0, 8'hFF, 1'b0}, 12, "ff");
            begin
                repeat (17) @(negedge clk);
                en_v[2] = 1'b0;
            end
        join
        repeat (60) @(negedge clk);
        check("ff_rd_count", 64'(rd_cnt[2]), 64'd2);
        check("ff_idle_busy", 64'(busy_v[2]), 64'd0);

        // Reset during data bit 4 of 0x5A; 0x3C follows, 0x5A is not resent.
        base = rd_cnt[0];
        push(8'h5A); push(8'h3C);
        wait_fall(0, 20, "r_start", n);
        repeat (21) @(negedge clk);
        check("r_pre_busy", 64'(busy_v[0]), 64'd1);
        reset = 1'b1;
        #1;
        check("r_tx", 64'(tx_v[0]), 64'd1);
        check("r_busy", 64'(busy_v[0]), 64'd0);
        check("r_rd", 64'(rd_v[0]), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_fall(0, 20, "r2_start", n);
        frame(0, {5'b0, 1'b1, 8'h3C, 1'b0}, 10, "after_rst");
        repeat (6) @(negedge clk);
        check("r_rd_count", 64'(rd_cnt[0] - base), 64'd2);
        check("r_fifo_empty", 64'(empty0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
